// File: rtl/s_mac_engine.sv
// Bit-serial dot-product MAC: ANDs and popcounts activation/weight bit-planes, then
// shift-accumulates over activation bits, weight bits and vectors under its own FSM.
module s_mac_engine #(
  parameter  int M      = 16,
  parameter  int PA_MAX = 8,
  parameter  int PW_MAX = 4,
  parameter  int MNO    = 288,
  localparam int OW     = $clog2(M) + PA_MAX + PW_MAX + $clog2(MNO) + 1,
  localparam int PAW    = $clog2(PA_MAX + 1),
  localparam int PWW    = $clog2(PW_MAX + 1),
  localparam int NVW    = $clog2(MNO + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           clear,
  input  logic [PAW-1:0] cfg_pa,
  input  logic [PWW-1:0] cfg_pw,
  input  logic [NVW-1:0] cfg_nvec,
  input  logic           cfg_sa,
  input  logic           cfg_sw,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   act,
  input  logic [M-1:0]   wei,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out_smac,
  output logic           busy
);

  localparam int PCW = $clog2(M) + 1;
  localparam int AAW = $clog2(M) + PA_MAX + 1;
  localparam int AWW = AAW + PW_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [PAW-1:0]        pa_r, i_cnt;
  logic [PWW-1:0]        pw_r, j_cnt;
  logic [NVW-1:0]        nvec_r, vec_cnt;
  logic                  sa_r, sw_r;
  logic signed [AAW-1:0] acc_a;
  logic signed [AWW-1:0] acc_w;
  logic signed [OW-1:0]  acc_o;

  logic [PAW-1:0]        pa_eff;
  logic [PWW-1:0]        pw_eff;
  logic [NVW-1:0]        nvec_eff;

  logic [M-1:0]          match;
  logic [PCW-1:0]        pop;
  logic                  i_first, j_first;
  logic signed [AAW-1:0] term, acc_a_nxt;
  logic signed [AWW-1:0] sterm, acc_w_nxt;
  logic signed [OW-1:0]  acc_o_nxt;

  // Zero means one; anything above the maximum saturates to the maximum.
  always_comb begin
    pa_eff = cfg_pa;
    if (cfg_pa == '0)
      pa_eff = PAW'(1);
    else if (cfg_pa > PAW'(PA_MAX))
      pa_eff = PAW'(PA_MAX);

    pw_eff = cfg_pw;
    if (cfg_pw == '0)
      pw_eff = PWW'(1);
    else if (cfg_pw > PWW'(PW_MAX))
      pw_eff = PWW'(PW_MAX);

    nvec_eff = cfg_nvec;
    if (cfg_nvec == '0)
      nvec_eff = NVW'(1);
    else if (cfg_nvec > NVW'(MNO))
      nvec_eff = NVW'(MNO);
  end

  // The MSB of a two's-complement operand carries negative weight, hence the negations.
  always_comb begin
    match = act & wei;
    pop   = '0;
    for (int k = 0; k < M; k++)
      pop = pop + PCW'(match[k]);

    i_first = (i_cnt == pa_r - 1'b1);
    j_first = (j_cnt == pw_r - 1'b1);

    term = {{(AAW-PCW){1'b0}}, pop};
    if (sa_r && i_first)
      term = -term;
    acc_a_nxt = term;
    if (!i_first)
      acc_a_nxt = (acc_a <<< 1) + term;

    sterm = {{(AWW-AAW){acc_a_nxt[AAW-1]}}, acc_a_nxt};
    if (sw_r && j_first)
      sterm = -sterm;
    acc_w_nxt = sterm;
    if (!j_first)
      acc_w_nxt = (acc_w <<< 1) + sterm;

    acc_o_nxt = acc_o + {{(OW-AWW){acc_w_nxt[AWW-1]}}, acc_w_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pa_r      <= '0;
      pw_r      <= '0;
      nvec_r    <= '0;
      sa_r      <= 1'b0;
      sw_r      <= 1'b0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      vec_cnt   <= '0;
      acc_a     <= '0;
      acc_w     <= '0;
      acc_o     <= '0;
      out_smac  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      i_cnt     <= '0;
      j_cnt     <= '0;
      vec_cnt   <= '0;
      acc_a     <= '0;
      acc_w     <= '0;
      acc_o     <= '0;
      out_smac  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pa_r     <= pa_eff;
            pw_r     <= pw_eff;
            nvec_r   <= nvec_eff;
            sa_r     <= cfg_sa;
            sw_r     <= cfg_sw;
            i_cnt    <= pa_eff - 1'b1;
            j_cnt    <= pw_eff - 1'b1;
            vec_cnt  <= '0;
            acc_a    <= '0;
            acc_w    <= '0;
            acc_o    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Activation bits are the inner loop, weight bits the middle, vectors the outer.
          if (in_valid) begin
            acc_a <= acc_a_nxt;
            if (i_cnt != '0) begin
              i_cnt <= i_cnt - 1'b1;
            end else begin
              i_cnt <= pa_r - 1'b1;
              acc_w <= acc_w_nxt;
              if (j_cnt != '0) begin
                j_cnt <= j_cnt - 1'b1;
              end else begin
                j_cnt <= pw_r - 1'b1;
                if (vec_cnt == nvec_r - 1'b1) begin
                  vec_cnt   <= '0;
                  acc_o     <= '0;
                  out_smac  <= acc_o_nxt;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
                end else begin
                  vec_cnt <= vec_cnt + 1'b1;
                  acc_o   <= acc_o_nxt;
                end
              end
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_mac_engine.sv
// Randomised scoreboard bench for s_mac_engine: lane values are turned into bit-planes,
// and each expected result is the plain signed dot product of those values.
module tb_s_mac_engine;

  localparam int M      = 16;
  localparam int PA_MAX = 8;
  localparam int PW_MAX = 4;
  localparam int MNO    = 288;
  localparam int OW     = $clog2(M) + PA_MAX + PW_MAX + $clog2(MNO) + 1;
  localparam int PAW    = $clog2(PA_MAX + 1);
  localparam int PWW    = $clog2(PW_MAX + 1);
  localparam int NVW    = $clog2(MNO + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           clear = 1'b0;
  logic [PAW-1:0] cfg_pa = '0;
  logic [PWW-1:0] cfg_pw = '0;
  logic [NVW-1:0] cfg_nvec = '0;
  logic           cfg_sa = 1'b0;
  logic           cfg_sw = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [M-1:0]   act = '0;
  logic [M-1:0]   wei = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [OW-1:0]  out_smac;
  logic           busy;

  int     checks = 0;
  int     errors = 0;
  longint exp_q[$];
  int     a_vals[$];
  int     w_vals[$];

  s_mac_engine #(.M(M), .PA_MAX(PA_MAX), .PW_MAX(PW_MAX), .MNO(MNO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .cfg_pa(cfg_pa), .cfg_pw(cfg_pw), .cfg_nvec(cfg_nvec),
    .cfg_sa(cfg_sa), .cfg_sw(cfg_sw),
    .in_valid(in_valid), .in_ready(in_ready), .act(act), .wei(wei),
    .out_valid(out_valid), .out_ready(out_ready), .out_smac(out_smac), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int eff(input int c, input int mx);
    return (c == 0) ? 1 : ((c > mx) ? mx : c);
  endfunction

  function automatic int randVal(input int bits, input bit sgn);
    int v;
    v = int'($urandom_range(0, (1 << bits) - 1));
    if (sgn && v >= (1 << (bits - 1)))
      v -= (1 << bits);
    return v;
  endfunction

  task automatic fillConst(input int nv, input int a, input int w);
    a_vals.delete();
    w_vals.delete();
    for (int n = 0; n < nv * M; n++) begin
      a_vals.push_back(a);
      w_vals.push_back(w);
    end
  endtask

  task automatic fillRandom(input int nv, input int pa, input int pw, input bit sa, input bit sw);
    a_vals.delete();
    w_vals.delete();
    for (int n = 0; n < nv * M; n++) begin
      a_vals.push_back(randVal(pa, sa));
      w_vals.push_back(randVal(pw, sw));
    end
  endtask

  // Monitor: every handshaken result is matched against the oldest expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          longint e;
          e = exp_q.pop_front();
          checkOutput("out_smac", longint'($signed(out_smac)), e);
        end
      end
    end
  end

  // abort_at >= 0 stops the job before that beat, by reset (abort_clear=0) or clear (=1).
  task automatic applyStimulus(input int pa_c, input int pw_c, input int nv_c,
                               input bit sa, input bit sw, input int gap_pct,
                               input int abort_at, input bit abort_clear);
    int     pa = eff(pa_c, PA_MAX);
    int     pw = eff(pw_c, PW_MAX);
    int     nv = eff(nv_c, MNO);
    longint expected = 0;
    int     beat = 0;
    int     wait_cnt = 0;
    bit     last;
    for (int n = 0; n < nv * M; n++)
      expected += longint'(a_vals[n]) * longint'(w_vals[n]);

    while (busy !== 1'b0 && wait_cnt < 2000) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checkOutput("idle_before_start", longint'(busy), 0);

    cfg_pa = PAW'(pa_c);
    cfg_pw = PWW'(pw_c);
    cfg_nvec = NVW'(nv_c);
    cfg_sa = sa;
    cfg_sw = sw;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("start_accepted", longint'(busy), 1);

    for (int v = 0; v < nv; v++) begin
      for (int j = pw - 1; j >= 0; j--) begin
        for (int i = pa - 1; i >= 0; i--) begin
          if (beat == abort_at) begin
            in_valid = 1'b0;
            if (abort_clear) begin
              clear = 1'b1;
              @(posedge clk); #1;
              clear = 1'b0;
              checkOutput("clear_busy", longint'(busy), 0);
              checkOutput("clear_in_ready", longint'(in_ready), 0);
              checkOutput("clear_out_smac", longint'(out_smac), 0);
            end else begin
              rst_n = 1'b0;
              #1;
              checkOutput("rst_in_ready", longint'(in_ready), 0);
              checkOutput("rst_out_valid", longint'(out_valid), 0);
              checkOutput("rst_busy", longint'(busy), 0);
              checkOutput("rst_out_smac", longint'(out_smac), 0);
              @(posedge clk); #1;
              rst_n = 1'b1;
            end
            return;
          end
          if (int'($urandom_range(0, 99)) < gap_pct) begin
            in_valid = 1'b0;
            act = M'($urandom);
            wei = M'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          for (int k = 0; k < M; k++) begin
            act[k] = 1'((a_vals[v * M + k] >>> i) & 1);
            wei[k] = 1'((w_vals[v * M + k] >>> j) & 1);
          end
          in_valid = 1'b1;
          last = (v == nv - 1) && (j == 0) && (i == 0);
          @(negedge clk);
          wait_cnt = 0;
          while (!in_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
          end
          if (!in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
          end
          if (last)
            checkOutput("out_valid_before_final", longint'(out_valid), 0);
          @(posedge clk); #1;
          beat++;
        end
      end
    end
    in_valid = 1'b0;
    exp_q.push_back(expected);
    checkOutput("out_valid_latency", longint'(out_valid), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pa_c, pw_c, nv_c;
    bit sa, sw;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_in_ready", longint'(in_ready), 0);
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_out_smac", longint'(out_smac), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single-beat unsigned job");
    fillConst(1, 1, 0);
    for (int k = 0; k < 8; k++) w_vals[k] = 1;
    applyStimulus(1, 1, 1, 1'b0, 1'b0, 0, -1, 1'b0);
    drain();

    $display("[TB] signed 2x2 jobs");
    fillConst(1, -1, -1);
    applyStimulus(2, 2, 1, 1'b1, 1'b1, 0, -1, 1'b0);
    fillConst(1, -1, 3);
    applyStimulus(2, 2, 1, 1'b1, 1'b0, 0, -1, 1'b0);
    drain();

    $display("[TB] full-precision unsigned, with and without bubbles");
    fillConst(3, 255, 15);
    applyStimulus(8, 4, 3, 1'b0, 1'b0, 0, -1, 1'b0);
    applyStimulus(8, 4, 3, 1'b0, 1'b0, 40, -1, 1'b0);
    drain();

    $display("[TB] output backpressure");
    out_ready = 1'b0;
    fillRandom(2, 3, 2, 1'b1, 1'b0);
    applyStimulus(3, 2, 2, 1'b1, 1'b0, 0, -1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", longint'(out_valid), 1);
      checkOutput("bp_hold_value", longint'($signed(out_smac)), exp_q[0]);
      checkOutput("bp_in_ready", longint'(in_ready), 0);
      @(posedge clk); #1;
      cfg_pa = PAW'(1);
      cfg_pw = PWW'(1);
      cfg_nvec = NVW'(1);
      start = (c < 3);
    end
    start = 1'b0;
    checkOutput("bp_busy", longint'(busy), 1);
    out_ready = 1'b1;
    fillRandom(1, 4, 3, 1'b0, 1'b1);
    applyStimulus(4, 3, 1, 1'b0, 1'b1, 0, -1, 1'b0);
    drain();

    $display("[TB] reset and clear aborts");
    fillRandom(1, 8, 4, 1'b1, 1'b1);
    applyStimulus(8, 4, 1, 1'b1, 1'b1, 0, 10, 1'b0);
    fillConst(1, 5, 3);
    applyStimulus(4, 2, 1, 1'b0, 1'b0, 0, -1, 1'b0);
    drain();
    cfg_pa = PAW'(2);
    cfg_pw = PWW'(2);
    cfg_nvec = NVW'(1);
    start = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b0;
    checkOutput("clear_start_busy", longint'(busy), 0);
    checkOutput("clear_start_in_ready", longint'(in_ready), 0);
    checkOutput("clear_start_out_smac", longint'(out_smac), 0);
    fillConst(1, 7, 2);
    applyStimulus(3, 2, 1, 1'b0, 1'b0, 0, 3, 1'b1);
    fillRandom(2, 5, 3, 1'b1, 1'b0);
    applyStimulus(5, 3, 2, 1'b1, 1'b0, 20, -1, 1'b0);
    drain();

    $display("[TB] config clamping");
    fillConst(1, 0, 0);
    a_vals[0] = 1;
    w_vals[0] = 8;
    applyStimulus(0, 7, 1, 1'b0, 1'b0, 0, -1, 1'b0);
    drain();

    $display("[TB] randomised jobs");
    for (int r = 0; r < 10; r++) begin
      pa_c = int'($urandom_range(0, 10));
      pw_c = int'($urandom_range(0, 7));
      nv_c = int'($urandom_range(0, 4));
      sa = 1'($urandom);
      sw = 1'($urandom);
      fillRandom(eff(nv_c, MNO), eff(pa_c, PA_MAX), eff(pw_c, PW_MAX), sa, sw);
      applyStimulus(pa_c, pw_c, nv_c, sa, sw, 30, -1, 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_mac_engine.md
Name: s_mac_engine

Overview:
- Self-sequenced, runtime-configurable bit-serial signed/unsigned dot-product MAC.
- Each beat delivers one M-lane activation bit-plane and one M-lane weight bit-plane; the block ANDs and popcounts them, then shift-accumulates over activation bits, weight bits and NVEC vectors.
- An internal FSM replaces all externally driven accumulator enables; valid/ready handshakes on input and output.
- Sits between the bit-plane buffers and the output/requantisation stage, one instance per output channel.

Parameters:
M, 16, lanes per bit-plane (≥2)
PA_MAX, 8, maximum activation precision in bits
PW_MAX, 4, maximum weight precision in bits
MNO, 288, maximum vectors accumulated per result
OW, $clog2(M)+PA_MAX+PW_MAX+$clog2(MNO)+1, output width (derived, do not override)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  latch cfg_* and begin a job; honoured only in IDLE
clear  in  1  synchronous abort to IDLE
cfg_pa  in  $clog2(PA_MAX+1)  activation bits for this job
cfg_pw  in  $clog2(PW_MAX+1)  weight bits for this job
cfg_nvec  in  $clog2(MNO+1)  vectors to accumulate
cfg_sa  in  1  1 = activations two's complement
cfg_sw  in  1  1 = weights two's complement
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid & in_ready
act  in  M  activation bit-plane
wei  in  M  weight bit-plane
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_smac  out  OW  signed two's-complement result
busy  out  1  state != IDLE

Behaviour:
- Reset: FSM = IDLE; all accumulators and counters = 0; in_ready, out_valid, busy = 0; out_smac = 0. Reset mid-job discards the job.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start: cfg_* are latched. A cfg value of 0 is treated as 1; values above the maximum are treated as PA_MAX / PW_MAX / MNO.
  - RUN→DONE on acceptance of the final beat of the final vector.
  - DONE→IDLE on out_ready.
- in_ready = 1 only in RUN.
- start outside IDLE is ignored.
- clear in any state: next state IDLE, accumulators zeroed, out_valid dropped. clear beats start in the same cycle.
- Beat order per vector: weight bit j from pw-1 down to 0 (outer loop), activation bit i from pa-1 down to 0 (inner loop). That is pa·pw beats per vector and pa·pw·nvec beats per job.
- Accepted beat arithmetic:
  - p = popcount(act & wei), width $clog2(M)+1.
  - t = −p if (cfg_sa & i == pa−1), else p.
  - acc_a ← (i == pa−1 ? 0 : acc_a<<1) + t.
- On the beat with i == 0:
  - s = −acc_a_new if (cfg_sw & j == pw−1), else acc_a_new.
  - acc_w ← (j == pw−1 ? 0 : acc_w<<1) + s.
- On the beat with i == 0 and j == 0: acc_o ← acc_o + acc_w_new.
- Accumulator widths, all signed, sign-extended on add:
  - acc_a: $clog2(M)+PA_MAX+1
  - acc_w: $clog2(M)+PA_MAX+PW_MAX+1
  - acc_o: OW
  - No overflow is possible within the parameter limits, so no saturation.
- Bubbles: in_valid low stalls all counters and accumulators with no state change.
- Output: out_smac is registered and out_valid rises the cycle after the final beat.
  - out_smac stays stable while out_valid & !out_ready.
  - acc_o is zeroed on entry to DONE.
  - out_smac returns to 0 only on reset/clear; otherwise it holds until the next result.
- Back-to-back jobs: start may be asserted in the cycle after the DONE→IDLE handshake.
- Counters (i, j, vec) wrap to their start values at the end of each loop. The vec counter reaching nvec−1 at i == j == 0 marks the final beat.

Test Plan:
1. Unsigned pa=1, pw=1, nvec=1; one beat act=16'hFFFF, wei=16'h00FF → out_smac=8, out_valid one cycle after the beat.
2. Signed pa=2, pw=2, nvec=1; 4 beats all act=wei=16'hFFFF (every element −1×−1) → out_smac=16. Repeat with cfg_sw=0 (weight 3) → −48.
3. Unsigned pa=8, pw=4, nvec=3; 96 beats of all-ones planes (255×15 per lane) → out_smac=183600. Random in_valid gaps give the identical result.
4. Backpressure: hold out_ready=0 for 5 cycles after result → out_valid stays 1, out_smac stable, in_ready=0, start ignored. After the handshake, a new start is accepted the next cycle and its result is independent of the previous job.
5. Abort: assert rst_n=0 mid-RUN (beat 10 of 32) → all outputs 0 immediately. Repeat with clear asserted together with start → stays IDLE, busy=0. A subsequent clean job gives the correct value.
6. Config clamping: cfg_pa=0, cfg_pw=7 (PW_MAX=4) → job consumes exactly 1×4 beats per vector. With act=16'h0001 and weight bit-planes (MSB first) 1,0,0,0 (unsigned) → out_smac=8.
